// File: rtl/i2s_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// i2s_pkg : shared constants and pairing-FSM encoding for the stereo framer
// Rev 1.0
// ---------------------------------------------------------------------------
package i2s_pkg;

  localparam int DATA_W  = 32;
  localparam int FRAME_W = 2 * DATA_W;

  // Stereo frame layout matches the DAC input: left in the upper half
  localparam int L_MSB = FRAME_W - 1;
  localparam int L_LSB = DATA_W;
  localparam int R_MSB = DATA_W - 1;
  localparam int R_LSB = 0;

  typedef enum logic [0:0] {
    WAIT_L = 1'b0,
    WAIT_R = 1'b1
  } pair_state_e;

endpackage
`default_nettype wire

// File: rtl/i2s_stereo_framer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// i2s_stereo_framer_if : ADC sample inputs, AXI-stream frame output, status
// Rev 1.0
// ---------------------------------------------------------------------------
interface i2s_stereo_framer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_AW    = 4,
  parameter int CNT_W      = 16
);

  logic [DATA_WIDTH-1:0]   adc_l_tdata;
  logic [DATA_WIDTH-1:0]   adc_r_tdata;
  logic [1:0]              adc_tvalid;
  logic [1:0]              adc_tready;
  logic [2*DATA_WIDTH-1:0] m_tdata;
  logic                    m_tvalid;
  logic                    m_tready;
  logic [FIFO_AW:0]        fill_level;
  logic [CNT_W-1:0]        overflow_cnt;
  logic [CNT_W-1:0]        orphan_cnt;

  modport master (
    input  adc_l_tdata, adc_r_tdata, adc_tvalid, m_tready,
    output adc_tready, m_tdata, m_tvalid, fill_level, overflow_cnt, orphan_cnt
  );

  modport slave (
    output adc_l_tdata, adc_r_tdata, adc_tvalid, m_tready,
    input  adc_tready, m_tdata, m_tvalid, fill_level, overflow_cnt, orphan_cnt
  );

endinterface
`default_nettype wire

// File: rtl/i2s_stereo_framer_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_fifo_fwft : single-clock first-word-fall-through FIFO, 2**AW entries
// Rev 1.0
// ---------------------------------------------------------------------------
module sync_fifo_fwft #(
  parameter int WIDTH = 64,
  parameter int AW    = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_wr_en,
  input  wire logic [WIDTH-1:0] i_wr_data,
  input  wire logic             i_rd_en,
  output logic      [WIDTH-1:0] o_rd_data,
  output logic                  o_empty,
  output logic                  o_full,
  output logic      [AW:0]      o_count
);

  localparam int          DEPTH     = 2 ** AW;
  localparam logic [AW:0] C_PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_wr;
  logic             w_rd;

  // Extra pointer MSB distinguishes full from empty when the indices match
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count = r_wr_ptr - r_rd_ptr;

  assign w_wr = i_wr_en & ~o_full;
  assign w_rd = i_rd_en & ~o_empty;

  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2s_stereo_framer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// i2s_stereo_framer : pairs L/R ADC samples into {L,R} frames, FIFO to AXIS
// Rev 1.0
// ---------------------------------------------------------------------------
module i2s_stereo_framer
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int FIFO_AW    = 4,
  parameter int CNT_W      = 16
) (
  input  wire logic           clk,
  input  wire logic           rst,
  i2s_stereo_framer_if.master bus
);

  localparam int               FW        = 2 * DATA_WIDTH;
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  pair_state_e           r_state;
  pair_state_e           w_state_nxt;
  logic [DATA_WIDTH-1:0] r_held_l;
  logic                  w_capture;
  logic                  w_push;
  logic                  w_orphan;
  logic [FW-1:0]         w_frame;
  logic                  r_push;
  logic [FW-1:0]         r_frame;
  logic [FW-1:0]         w_head;
  logic                  w_empty;
  logic                  w_full;
  logic [FIFO_AW:0]      w_count;
  logic                  w_pop;
  logic                  w_overflow;
  logic [CNT_W-1:0]      r_overflow_cnt;
  logic [CNT_W-1:0]      r_orphan_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_push      = 1'b0;
    w_orphan    = 1'b0;
    w_frame     = {r_held_l, bus.adc_r_tdata};
    case (r_state)
      WAIT_L: begin
        case (bus.adc_tvalid)
          2'b10: begin
            w_capture   = 1'b1;
            w_state_nxt = WAIT_R;
          end
          2'b01: w_orphan = 1'b1;
          2'b11: begin
            w_push  = 1'b1;
            w_frame = {bus.adc_l_tdata, bus.adc_r_tdata};
          end
          default: ;
        endcase
      end
      WAIT_R: begin
        case (bus.adc_tvalid)
          2'b01: begin
            w_push      = 1'b1;
            w_state_nxt = WAIT_L;
          end
          2'b10: begin
            w_orphan  = 1'b1;
            w_capture = 1'b1;
          end
          2'b11: begin
            w_push    = 1'b1;
            w_capture = 1'b1;
          end
          default: ;
        endcase
      end
      default: w_state_nxt = WAIT_L;
    endcase
  end

  // Completed pairs are registered once before the FIFO write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= WAIT_L;
      r_held_l <= '0;
      r_push   <= 1'b0;
      r_frame  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_push  <= w_push;
      if (w_capture) begin
        r_held_l <= bus.adc_l_tdata;
      end
      if (w_push) begin
        r_frame <= w_frame;
      end
    end
  end

  sync_fifo_fwft #(
    .WIDTH (FW),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (r_push),
    .i_wr_data (r_frame),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_empty   (w_empty),
    .o_full    (w_full),
    .o_count   (w_count)
  );

  assign w_pop      = ~w_empty & bus.m_tready;
  assign w_overflow = r_push & w_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow_cnt <= '0;
      r_orphan_cnt   <= '0;
    end else begin
      if (w_overflow && (r_overflow_cnt != '1)) begin
        r_overflow_cnt <= r_overflow_cnt + C_CNT_ONE;
      end
      if (w_orphan && (r_orphan_cnt != '1)) begin
        r_orphan_cnt <= r_orphan_cnt + C_CNT_ONE;
      end
    end
  end

  assign bus.adc_tready   = 2'b11;
  assign bus.m_tdata      = w_head;
  assign bus.m_tvalid     = ~w_empty;
  assign bus.fill_level   = w_count;
  assign bus.overflow_cnt = r_overflow_cnt;
  assign bus.orphan_cnt   = r_orphan_cnt;

endmodule
`default_nettype wire

// File: doc/i2s_stereo_framer.md
# i2s_stereo_framer

Downstream of the I2S PMOD receiver: takes its independent left/right ADC sample streams, pairs them into 64-bit stereo frames `{L,R}` and buffers them in a FIFO. The output is an AXI-stream master whose data layout matches the I2S DAC input (`[63:32]` left, `[31:0]` right), so audio can loop back or feed a DSP chain. The ADC cannot be stalled, so the input side always accepts data. Frame loss is counted, never back-pressured.

## Interface
- `DATA_WIDTH`, 32, width of one channel sample.
- `FIFO_AW`, 4, FIFO address bits; depth = 2**FIFO_AW frames.
- `CNT_W`, 16, width of the saturating error counters.

- `clk`  in  1  single clock, same domain as the I2S block.
- `rst`  in  1  asynchronous, active-high reset.
- `adc_l_tdata`  in  DATA_WIDTH  left sample.
- `adc_r_tdata`  in  DATA_WIDTH  right sample.
- `adc_tvalid`  in  2  bit1 = left valid, bit0 = right valid.
- `adc_tready`  out  2  constant 2'b11 out of reset.
- `m_tdata`  out  2*DATA_WIDTH  `{L,R}` frame.
- `m_tvalid`  out  1  FIFO not empty.
- `m_tready`  in  1  consumer accepts the frame.
- `fill_level`  out  FIFO_AW+1  frames currently stored.
- `overflow_cnt`  out  CNT_W  frames dropped because the FIFO was full.
- `orphan_cnt`  out  CNT_W  unpaired samples discarded.

## Operation
- Pairing FSM, two states:
  - `WAIT_L`: reset state.
  - `WAIT_R`: holds a left sample in `held_l`.
- Behaviour per cycle, as a function of `adc_tvalid`:
  - `WAIT_L`, 2'b10: capture L into `held_l`, go to `WAIT_R`.
  - `WAIT_L`, 2'b01: discard R, `orphan_cnt++`, stay in `WAIT_L`.
  - `WAIT_L`, 2'b11: push `{L,R}` directly, stay in `WAIT_L`.
  - `WAIT_R`, 2'b01: push `{held_l,R}`, go to `WAIT_L`.
  - `WAIT_R`, 2'b10: the old `held_l` is discarded (`orphan_cnt++`), the new L is captured, stay in `WAIT_R`.
  - `WAIT_R`, 2'b11: push `{held_l,R}`, capture the new L, stay in `WAIT_R`.
  - Any state, 2'b00: no change.
- Push rules:
  - Push when `fill_level` < depth (the value before this edge) writes the frame.
  - Push when the FIFO is full drops the frame and increments `overflow_cnt`. This holds even if a pop happens in the same cycle; the full test uses the pre-edge count.
- Pop occurs when `m_tvalid && m_tready`.
  - Simultaneous push and pop on a non-full FIFO leaves `fill_level` unchanged.
- FIFO mode:
  - First-word-fall-through: `m_tdata` shows the head frame whenever `m_tvalid` is high.
  - `m_tdata` is stable while `m_tvalid && !m_tready`.
- Counters saturate at all-ones and do not wrap. They are cleared only by `rst`.
- Pointers wrap modulo depth. Full/empty is derived from an extra MSB on the pointers.

## Timing
- Reset values:
  - `adc_tready` = 2'b11.
  - `m_tvalid` = 0.
  - `m_tdata` = 0.
  - `fill_level` = 0.
  - Both counters = 0.
  - FSM in `WAIT_L`; `held_l` = 0.
- Reset assertion mid-operation:
  - FIFO contents are abandoned.
  - A held left sample is lost and is not counted.
  - Outputs return to their reset values asynchronously.
- Latency: a pair completed at edge k gives `m_tvalid` = 1 and `m_tdata` equal to that frame after edge k+1, if the FIFO was empty.
- `fill_level`, `overflow_cnt` and `orphan_cnt` update at the same edge as the push or pop that changes them.
- Throughput: one frame pushed and one frame popped per cycle.

## Structure
- Shared package `i2s_pkg`:
  - FSM state encoding (`WAIT_L`, `WAIT_R`).
  - `FRAME_W = 2*DATA_WIDTH`.
  - Frame field slice constants `L_MSB`/`L_LSB`/`R_MSB`/`R_LSB`.
- Sub-module `sync_fifo_fwft`, with parameters width and AW:
  - Inputs: write enable and data; read enable.
  - Outputs: data, empty, full, count.
  - Reset is async, active-high.
- The top level holds the pairing FSM, `held_l`, and the saturating counters.

## Test plan
- Nominal pairing:
  - Stimulus: L=32'h0000_1111, then R=32'h0000_2222 two cycles later, with `m_tready`=1.
  - Response: one frame 64'h0000_1111_0000_2222, with `m_tvalid` high one cycle after the R edge; `orphan_cnt`=0.
- Orphans:
  - Stimulus: R alone in `WAIT_L`, then L=A, L=B, R=C.
  - Response: `orphan_cnt`=2 and a single frame `{B,C}`.
- Simultaneous L and R:
  - Stimulus: 2'b11 with L=5, R=6 in `WAIT_L`; then L=7; then 2'b11 with L=8, R=9.
  - Response: frames `{5,6}` and `{7,9}`; FSM ends in `WAIT_R` with `held_l`=8.
- Overflow, with FIFO_AW=4 and `m_tready`=0:
  - Stimulus: push 18 frames, popping on the 18th push.
  - Response: 16 stored, `fill_level`=16 before the pop, `overflow_cnt`=2; the pop output is frame 1.
- Back-pressure and ordering:
  - Stimulus: random `m_tready` and a 1000-frame stream.
  - Response: the output sequence equals the input order with no loss while `fill_level` < 16, and `m_tdata` is stable during stalls.
- Async reset:
  - Stimulus: assert `rst` between clock edges while the FSM is in `WAIT_R` and 5 frames are queued.
  - Response: `m_tvalid` and `fill_level` drop to 0 immediately, and the next L/R pair after release yields exactly one frame.
